// File: rtl/data_cache_pkg.sv
// Shared types and geometry for the direct-mapped write-through data cache.
package data_cache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        WRITE  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int WORDS_PER_LINE = 4;
    localparam int BYTE_OFF_W     = 2;
    localparam int WORD_OFF_W     = 2;
    localparam int LINE_OFF_W     = BYTE_OFF_W + WORD_OFF_W;

    function automatic logic [3:0] byte_lane(input logic [1:0] off);
        return 4'b0001 << off;
    endfunction

endpackage

// File: rtl/cache_data_array.sv
// Valid/tag/data storage: one combinational read port and one byte-enabled word write port.
module cache_data_array
    import data_cache_pkg::*;
#(
    parameter int SETS  = 16,
    parameter int IDX_W = 4,
    parameter int TAG_W = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [IDX_W-1:0]      i_index,
    input  logic [WORD_OFF_W-1:0] i_rd_word,
    output logic                  o_rd_valid,
    output logic [TAG_W-1:0]      o_rd_tag,
    output logic [31:0]           o_rd_data,
    input  logic                  i_wr_en,
    input  logic [WORD_OFF_W-1:0] i_wr_word,
    input  logic [3:0]            i_wr_be,
    input  logic [31:0]           i_wr_data,
    input  logic                  i_fill,
    input  logic [TAG_W-1:0]      i_fill_tag,
    input  logic                  i_inv
);

    logic [SETS-1:0]  r_valid;
    logic [TAG_W-1:0] r_tag  [SETS];
    logic [31:0]      r_data [SETS][WORDS_PER_LINE];

    // Only the valid bits are reset; tag and data contents are don't-care until filled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (i_fill) begin
            r_valid[i_index] <= 1'b1;
        end else if (i_inv) begin
            r_valid[i_index] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (i_fill) begin
            r_tag[i_index] <= i_fill_tag;
        end
        if (i_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (i_wr_be[b]) begin
                    r_data[i_index][i_wr_word][8*b +: 8] <= i_wr_data[8*b +: 8];
                end
            end
        end
    end

    assign o_rd_valid = r_valid[i_index];
    assign o_rd_tag   = r_tag[i_index];
    assign o_rd_data  = r_data[i_index][i_rd_word];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache for the memory stage,
// refilling over a single-word req/ack bus and stalling the pipeline while busy.
module data_cache
    import data_cache_pkg::*;
#(
    parameter int SETS   = 16,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_re,
    input  logic              cpu_we,
    input  logic              cpu_byte_ld,
    input  logic              cpu_byte_st,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - LINE_OFF_W - IDX_W;
    localparam int LINE_W = ADDR_W - LINE_OFF_W;

    state_t                  r_state;
    logic [WORD_OFF_W-1:0]   r_cnt;
    logic                    r_mem_req;
    logic                    r_mem_we;
    logic [ADDR_W-1:0]       r_mem_addr;
    logic [31:0]             r_mem_wdata;
    logic [3:0]              r_mem_be;

    logic [TAG_W-1:0]        w_tag;
    logic [IDX_W-1:0]        w_index;
    logic [WORD_OFF_W-1:0]   w_word;
    logic [1:0]              w_byte;
    logic [LINE_W-1:0]       w_line;
    logic [ADDR_W-1:0]       w_word_addr;
    logic [WORD_OFF_W-1:0]   w_cnt_nxt;

    logic                    w_arr_valid;
    logic [TAG_W-1:0]        w_arr_tag;
    logic [31:0]             w_arr_rdata;
    logic                    w_hit;
    logic                    w_ack;
    logic                    w_idle;
    logic                    w_store;
    logic                    w_miss_ld;
    logic                    w_refill_wr;
    logic                    w_merge_wr;
    logic                    w_wr_en;
    logic [WORD_OFF_W-1:0]   w_wr_word;
    logic [3:0]              w_wr_be;
    logic [31:0]             w_wr_data;
    logic                    w_fill;
    logic [3:0]              w_st_be;
    logic [31:0]             w_st_data;
    logic [7:0]              w_sel_byte;
    logic [31:0]             w_rdata;

    assign w_tag       = cpu_addr[ADDR_W-1 -: TAG_W];
    assign w_index     = cpu_addr[LINE_OFF_W +: IDX_W];
    assign w_word      = cpu_addr[BYTE_OFF_W +: WORD_OFF_W];
    assign w_byte      = cpu_addr[1:0];
    assign w_line      = cpu_addr[ADDR_W-1:LINE_OFF_W];
    assign w_word_addr = {cpu_addr[ADDR_W-1:BYTE_OFF_W], 2'b00};
    assign w_cnt_nxt   = r_cnt + 2'd1;

    assign w_hit     = w_arr_valid && (w_arr_tag == w_tag);
    assign w_ack     = mem_ack && r_mem_req;
    assign w_idle    = (r_state == IDLE);
    assign w_store   = w_idle && cpu_we;
    assign w_miss_ld = w_idle && !cpu_we && cpu_re && !w_hit;

    assign cpu_stall = w_store || w_miss_ld || (r_state == REFILL) || (r_state == WRITE);

    assign w_st_be   = cpu_byte_st ? byte_lane(w_byte) : 4'hF;
    assign w_st_data = cpu_byte_st ? {4{cpu_wdata[7:0]}} : cpu_wdata;

    // The refill word and a store merge never coincide, so they share the single write port.
    assign w_refill_wr = (r_state == REFILL) && w_ack;
    assign w_merge_wr  = (r_state == WRITE) && w_ack && w_hit;
    assign w_wr_en     = w_refill_wr || w_merge_wr;
    assign w_wr_word   = w_refill_wr ? r_cnt : w_word;
    assign w_wr_be     = w_refill_wr ? 4'hF : r_mem_be;
    assign w_wr_data   = w_refill_wr ? mem_rdata : r_mem_wdata;
    assign w_fill      = w_refill_wr && (r_cnt == 2'd3);

    cache_data_array #(
        .SETS  (SETS),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_array (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_index    (w_index),
        .i_rd_word  (w_word),
        .o_rd_valid (w_arr_valid),
        .o_rd_tag   (w_arr_tag),
        .o_rd_data  (w_arr_rdata),
        .i_wr_en    (w_wr_en),
        .i_wr_word  (w_wr_word),
        .i_wr_be    (w_wr_be),
        .i_wr_data  (w_wr_data),
        .i_fill     (w_fill),
        .i_fill_tag (w_tag),
        .i_inv      (w_miss_ld)
    );

    always_comb begin
        w_sel_byte = w_arr_rdata[7:0];
        case (w_byte)
            2'd0:    w_sel_byte = w_arr_rdata[7:0];
            2'd1:    w_sel_byte = w_arr_rdata[15:8];
            2'd2:    w_sel_byte = w_arr_rdata[23:16];
            default: w_sel_byte = w_arr_rdata[31:24];
        endcase
    end

    // Load data is driven only for a hit in IDLE so that reset and stall cycles read as zero.
    always_comb begin
        w_rdata = '0;
        if (w_idle && cpu_re && !cpu_we && w_hit) begin
            w_rdata = cpu_byte_ld ? {24'b0, w_sel_byte} : w_arr_rdata;
        end
    end

    assign cpu_rdata = w_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cpu_we) begin
                        r_state     <= WRITE;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= w_word_addr;
                        r_mem_wdata <= w_st_data;
                        r_mem_be    <= w_st_be;
                    end else if (cpu_re && !w_hit) begin
                        r_state    <= REFILL;
                        r_cnt      <= '0;
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= {w_line, 2'b00, 2'b00};
                    end
                end
                REFILL: begin
                    if (w_ack) begin
                        if (r_cnt == 2'd3) begin
                            r_state   <= IDLE;
                            r_cnt     <= '0;
                            r_mem_req <= 1'b0;
                        end else begin
                            r_cnt      <= w_cnt_nxt;
                            r_mem_addr <= {w_line, w_cnt_nxt, 2'b00};
                        end
                    end
                end
                WRITE: begin
                    if (w_ack) begin
                        r_state   <= DONE;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_be    = r_mem_be;

endmodule
